// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a framed host byte stream (A5, LEN, words, XOR checksum)
// and writes 16-bit words to imem from address 0, holding the CPU while loading.
module imem_loader #(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [15:0]       word_count
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LEN_HI  = 4'd1;
  localparam logic [3:0] S_LEN_LO  = 4'd2;
  localparam logic [3:0] S_DATA_HI = 4'd3;
  localparam logic [3:0] S_DATA_LO = 4'd4;
  localparam logic [3:0] S_WRITE   = 4'd5;
  localparam logic [3:0] S_CHECK   = 4'd6;
  localparam logic [3:0] S_DONE    = 4'd7;
  localparam logic [3:0] S_ERROR   = 4'd8;

  localparam int          TW  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  logic [3:0]    state;
  logic [15:0]   len;
  logic [7:0]    hi_byte;
  logic [7:0]    chk;
  logic [TW-1:0] tmo;
  logic          acc;
  logic          timed;
  logic          is_sync;

  assign in_ready = (state != S_WRITE);
  assign acc      = in_valid & in_ready;
  assign is_sync  = acc && (in_data == 8'hA5);
  assign timed    = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA_HI) ||
                    (state == S_DATA_LO) || (state == S_WRITE) || (state == S_CHECK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
      len        <= '0;
      hi_byte    <= '0;
      chk        <= '0;
      tmo        <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (is_sync) begin
            state      <= S_LEN_HI;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
            chk        <= '0;
            tmo        <= '0;
            cpu_hold   <= 1'b1;
          end
        end
        S_LEN_HI: if (acc) begin
          len[15:8] <= in_data;
          chk       <= chk ^ in_data;
          state     <= S_LEN_LO;
        end
        S_LEN_LO: if (acc) begin
          len[7:0] <= in_data;
          chk      <= chk ^ in_data;
          // Oversized programs are rejected before anything is written
          if ({1'b0, len[15:8], in_data} > CAP) begin
            state <= S_ERROR;
            error <= 1'b1;
          end else if ({len[15:8], in_data} == 16'd0) begin
            state <= S_CHECK;
          end else begin
            state <= S_DATA_HI;
          end
        end
        S_DATA_HI: if (acc) begin
          hi_byte <= in_data;
          chk     <= chk ^ in_data;
          state   <= S_DATA_LO;
        end
        S_DATA_LO: if (acc) begin
          imem_we    <= 1'b1;
          imem_addr  <= word_count[ADDR_W-1:0];
          imem_wdata <= {hi_byte, in_data};
          chk        <= chk ^ in_data;
          state      <= S_WRITE;
        end
        S_WRITE: begin
          word_count <= word_count + 16'd1;
          state      <= (word_count + 16'd1 == len) ? S_CHECK : S_DATA_HI;
        end
        S_CHECK: if (acc) begin
          if (in_data == chk) begin
            state    <= S_DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            state <= S_ERROR;
            error <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
      // An accepted byte always wins over an expiring timeout
      if (timed) begin
        if (acc) begin
          tmo <= '0;
        end else if (tmo == TW'(TIMEOUT_CYC - 1)) begin
          state <= S_ERROR;
          error <= 1'b1;
        end else begin
          tmo <= tmo + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (ADDR_W=2, TIMEOUT_CYC=16); writes are logged by a negedge monitor.
module tb_imem_loader;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          error;
  logic [15:0]   word_count;

  imem_loader #(.ADDR_W(AW), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
    .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int            wr_n = 0;
  logic [AW-1:0] wr_addr [16];
  logic [15:0]   wr_data [16];
  int            we_dbl = 0;
  logic          prev_we = 1'b0;
  int            rdy_low = 0;
  bit            mon_en = 1'b0;

  always @(negedge clk) begin
    if (imem_we && wr_n < 16) begin
      wr_addr[wr_n] = imem_addr;
      wr_data[wr_n] = imem_wdata;
      wr_n++;
    end
    if (imem_we && prev_we) we_dbl++;
    prev_we = imem_we;
    if (mon_en && !in_ready) rdy_low++;
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_byte_stall: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b want 0", imem_we); end
    checks++; if (imem_addr !== '0 || imem_wdata !== 16'h0) begin errors++; $display("FAIL reset_addr_data: got %0h/%h want 0/0000", imem_addr, imem_wdata); end
    checks++; if ({cpu_hold, done, error} !== 3'b000) begin errors++; $display("FAIL reset_flags: hold/done/err=%b want 000", {cpu_hold, done, error}); end
    checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL reset_wc: got %0d want 0", word_count); end
  endtask

  task automatic test_good_frame();
    wr_n = 0;
    send_byte(8'hA5);
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL good_hold_on_sync: got %0b want 1", cpu_hold); end
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
    checks++; if (done !== 1'b0 || cpu_hold !== 1'b1) begin errors++; $display("FAIL good_pre_chk: done=%0b hold=%0b want 0/1", done, cpu_hold); end
    send_byte(8'h42);
    checks++; if ({done, error, cpu_hold} !== 3'b100) begin errors++; $display("FAIL good_flags: done/err/hold=%b want 100", {done, error, cpu_hold}); end
    checks++; if (word_count !== 16'd2) begin errors++; $display("FAIL good_wc: got %0d want 2", word_count); end
    checks++; if (wr_n !== 2) begin errors++; $display("FAIL good_wr_n: got %0d want 2", wr_n); end
    checks++; if (wr_addr[0] !== 2'd0 || wr_data[0] !== 16'h1234) begin errors++; $display("FAIL good_w0: got %0d/%h want 0/1234", wr_addr[0], wr_data[0]); end
    checks++; if (wr_addr[1] !== 2'd1 || wr_data[1] !== 16'hABCD) begin errors++; $display("FAIL good_w1: got %0d/%h want 1/abcd", wr_addr[1], wr_data[1]); end
  endtask

  task automatic test_bad_chk();
    wr_n = 0;
    send_byte(8'hA5);
    checks++; if (done !== 1'b0 || word_count !== 16'd0) begin errors++; $display("FAIL bad_sync_clear: done=%0b wc=%0d want 0/0", done, word_count); end
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'h43);
    checks++; if (wr_n !== 2) begin errors++; $display("FAIL bad_wr_n: got %0d want 2", wr_n); end
    checks++; if ({done, error, cpu_hold} !== 3'b011) begin errors++; $display("FAIL bad_flags: done/err/hold=%b want 011", {done, error, cpu_hold}); end
  endtask

  task automatic test_garbage_empty();
    do_reset();
    wr_n = 0;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    checks++; if ({cpu_hold, done, error} !== 3'b000) begin errors++; $display("FAIL garbage_idle: hold/done/err=%b want 000", {cpu_hold, done, error}); end
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    checks++; if ({done, error, cpu_hold} !== 3'b100) begin errors++; $display("FAIL empty_flags: done/err/hold=%b want 100", {done, error, cpu_hold}); end
    checks++; if (word_count !== 16'd0 || wr_n !== 0) begin errors++; $display("FAIL empty_counts: wc=%0d writes=%0d want 0/0", word_count, wr_n); end
  endtask

  task automatic test_capacity();
    logic [15:0] exp_d [4];
    exp_d[0] = 16'h0102; exp_d[1] = 16'h0304; exp_d[2] = 16'h0506; exp_d[3] = 16'h0708;
    wr_n = 0;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h05);
    checks++; if ({error, done, cpu_hold} !== 3'b101) begin errors++; $display("FAIL cap_over: err/done/hold=%b want 101", {error, done, cpu_hold}); end
    checks++; if (wr_n !== 0) begin errors++; $display("FAIL cap_over_writes: got %0d want 0", wr_n); end
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h04);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    send_byte(8'h0C);
    checks++; if ({done, error} !== 2'b10 || word_count !== 16'd4) begin errors++; $display("FAIL cap_full: done/err=%b wc=%0d want 10/4", {done, error}, word_count); end
    checks++; if (wr_n !== 4) begin errors++; $display("FAIL cap_full_writes: got %0d want 4", wr_n); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_addr[i] !== 2'(i) || wr_data[i] !== exp_d[i]) begin
        errors++; $display("FAIL cap_w%0d: got %0d/%h want %0d/%h", i, wr_addr[i], wr_data[i], i, exp_d[i]);
      end
    end
  endtask

  task automatic test_timeout();
    wr_n = 0;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h12);
    repeat (15) @(posedge clk);
    #1;
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL tmo_early: error=%0b after 15 idle cycles want 0", error); end
    @(posedge clk);
    #1;
    checks++; if ({error, cpu_hold, done} !== 3'b110) begin errors++; $display("FAIL tmo_fire: err/hold/done=%b want 110", {error, cpu_hold, done}); end
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'hBE); send_byte(8'hEF);
    send_byte(8'h50);
    checks++; if ({done, error, cpu_hold} !== 3'b100) begin errors++; $display("FAIL tmo_recover: done/err/hold=%b want 100", {done, error, cpu_hold}); end
    checks++; if (wr_n !== 1 || wr_addr[0] !== 2'd0 || wr_data[0] !== 16'hBEEF) begin errors++; $display("FAIL tmo_recover_w: n=%0d %0d/%h want 1 0/beef", wr_n, wr_addr[0], wr_data[0]); end
  endtask

  task automatic test_rst_mid();
    wr_n = 0;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB);
    checks++; if (imem_we !== 1'b0 || imem_wdata !== 16'h1234) begin errors++; $display("FAIL mid_hold_data: we=%0b data=%h want 0/1234", imem_we, imem_wdata); end
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hCD; rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    checks++; if ({in_ready, imem_we, cpu_hold, done, error} !== 5'b10000) begin errors++; $display("FAIL mid_rst_flags: rdy/we/hold/done/err=%b want 10000", {in_ready, imem_we, cpu_hold, done, error}); end
    checks++; if (imem_addr !== '0 || imem_wdata !== 16'h0 || word_count !== 16'd0) begin errors++; $display("FAIL mid_rst_regs: addr=%0d data=%h wc=%0d want 0/0000/0", imem_addr, imem_wdata, word_count); end
    @(negedge clk);
    checks++; if (wr_n !== 1) begin errors++; $display("FAIL mid_rst_writes: got %0d want 1", wr_n); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] fr [10];
    fr[0] = 8'hA5; fr[1] = 8'h00; fr[2] = 8'h03; fr[3] = 8'hDE; fr[4] = 8'hAD;
    fr[5] = 8'hBE; fr[6] = 8'hEF; fr[7] = 8'h12; fr[8] = 8'h34; fr[9] = 8'h07;
    wr_n = 0;
    rdy_low = 0;
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) send_byte(fr[i]);
    @(negedge clk);
    mon_en = 1'b0;
    checks++; if (rdy_low !== 3) begin errors++; $display("FAIL b2b_ready_low: got %0d cycles want 3", rdy_low); end
    checks++; if (wr_n !== 3 || we_dbl !== 0) begin errors++; $display("FAIL b2b_writes: n=%0d dbl=%0d want 3/0", wr_n, we_dbl); end
    checks++; if (wr_data[0] !== 16'hDEAD || wr_data[1] !== 16'hBEEF || wr_data[2] !== 16'h1234 || wr_addr[2] !== 2'd2) begin
      errors++; $display("FAIL b2b_data: %h %h %h @%0d want dead beef 1234 @2", wr_data[0], wr_data[1], wr_data[2], wr_addr[2]);
    end
    checks++; if ({done, error, cpu_hold} !== 3'b100 || word_count !== 16'd3) begin errors++; $display("FAIL b2b_flags: done/err/hold=%b wc=%0d want 100/3", {done, error, cpu_hold}, word_count); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_garbage_empty();
    test_capacity();
    test_timeout();
    test_rst_mid();
    test_back_to_back();
    checks++; if (we_dbl !== 0) begin errors++; $display("FAIL we_single_cycle: %0d double-length strobes want 0", we_dbl); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
